// File: rtl/pic_pkg.sv
// Shared constants and types for the 8259 interrupt scheduler.
// Included by the scheduler top and the priority resolver.
package pic_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_ACK1 = 2'd2;

    localparam logic [2:0] OCW2_ROT_CLR = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI  = 3'b001;
    localparam logic [2:0] OCW2_NOP     = 3'b010;
    localparam logic [2:0] OCW2_SP_EOI  = 3'b011;
    localparam logic [2:0] OCW2_ROT_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS  = 3'b101;
    localparam logic [2:0] OCW2_SET_PRI = 3'b110;
    localparam logic [2:0] OCW2_ROT_SP  = 3'b111;

    localparam logic [2:0] LP_RESET    = 3'd7;
    localparam logic [2:0] SPURIOUS_IR = 3'd7;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } win_t;

    // 0 = highest priority, 7 = lowest, relative to LP
    function automatic logic [2:0] prio_rank(
        input logic [2:0] idx,
        input logic [2:0] lp
    );
        return idx - lp - 3'd1;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating find-first: the bit after LP has highest priority,
// LP itself has the lowest.
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [7:0] vec,
    input  logic [2:0] lp,
    output win_t       win
);

    logic [2:0] pos;

    always_comb begin
        win = '0;
        pos = '0;
        for (int i = 7; i >= 0; i--) begin
            pos = lp + 3'(i) + 3'd1;
            if (vec[pos]) begin
                win.valid = 1'b1;
                win.idx   = pos;
            end
        end
    end

endmodule

// File: rtl/pic_interrupt_scheduler.sv
// 8259 IR capture, priority arbitration, INTA sequencing and
// OCW2 EOI/rotation handling.
module pic_interrupt_scheduler
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST_,
    input  logic [7:0] IR,
    input  logic       LEVEL,
    input  logic [7:0] MASK,
    input  logic       AEOI,
    input  logic       OCW2_WR,
    input  logic [7:0] OCW2,
    input  logic       INTA_ACK,
    output logic       INT,
    output logic [2:0] IR_NUM,
    output logic [7:0] IRR,
    output logic [7:0] ISR,
    output logic [1:0] INTA_COUNT
);

    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] ir_s, ir_d;
    logic [1:0] state;
    logic [2:0] lp;
    logic       rot_aeoi, spur_q;
    win_t       req_w, isr_w;

    logic [7:0] irr_next, ack_set, ack_clr;
    logic [7:0] eoi_clr, isr_top_bit;
    logic       lp_wr, rot_wr, rot_val;
    logic [2:0] lp_val;
    logic       ack1_hit, ack2_hit, aeoi_done, req_above;
    logic       unused_ocw2;

    assign ir_s        = sync_q[SYNC_STAGES-1];
    assign unused_ocw2 = ^OCW2[4:3];

    pic_priority_resolver u_req (
        .vec (IRR & ~MASK),
        .lp  (lp),
        .win (req_w)
    );

    pic_priority_resolver u_isr (
        .vec (ISR),
        .lp  (lp),
        .win (isr_w)
    );

    assign ack1_hit  = (state == ST_PEND) && INTA_ACK;
    assign ack2_hit  = (state == ST_ACK1) && INTA_ACK;
    assign aeoi_done = ack2_hit && AEOI && !spur_q;
    assign req_above = req_w.valid && (!isr_w.valid ||
        prio_rank(req_w.idx, lp) < prio_rank(isr_w.idx, lp));
    assign isr_top_bit = isr_w.valid ? (8'b1 << isr_w.idx) : 8'b0;

    always_comb begin
        ack_set = '0;
        if (ack1_hit && req_w.valid)
            ack_set = 8'b1 << req_w.idx;
        ack_clr = LEVEL ? 8'b0 : ack_set;
        // edge mode: a bit also drops if its synced line falls first
        irr_next = LEVEL ? ir_s
                 : ((IRR | (ir_s & ~ir_d)) & ir_s & ~ack_clr);
    end

    always_comb begin
        eoi_clr = aeoi_done ? (8'b1 << IR_NUM) : 8'b0;
        lp_wr   = 1'b0;
        lp_val  = lp;
        rot_wr  = 1'b0;
        rot_val = rot_aeoi;
        if (OCW2_WR) begin
            unique case (OCW2[7:5])
                OCW2_NS_EOI: eoi_clr = eoi_clr | isr_top_bit;
                OCW2_SP_EOI: eoi_clr = eoi_clr | (8'b1 << OCW2[2:0]);
                OCW2_ROT_NS: begin
                    eoi_clr = eoi_clr | isr_top_bit;
                    lp_wr   = isr_w.valid;
                    lp_val  = isr_w.idx;
                end
                OCW2_ROT_SP: begin
                    eoi_clr = eoi_clr | (8'b1 << OCW2[2:0]);
                    lp_wr   = 1'b1;
                    lp_val  = OCW2[2:0];
                end
                OCW2_SET_PRI: begin
                    lp_wr  = 1'b1;
                    lp_val = OCW2[2:0];
                end
                OCW2_ROT_SET: begin
                    rot_wr  = 1'b1;
                    rot_val = 1'b1;
                end
                OCW2_ROT_CLR: begin
                    rot_wr  = 1'b1;
                    rot_val = 1'b0;
                end
                OCW2_NOP: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= '0;
            ir_d <= '0;
        end else begin
            sync_q[0] <= IR;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            ir_d <= ir_s;
        end
    end

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            IRR      <= '0;
            ISR      <= '0;
            lp       <= LP_RESET;
            rot_aeoi <= 1'b0;
        end else begin
            IRR <= irr_next;
            ISR <= (ISR & ~eoi_clr) | ack_set;
            if (lp_wr)
                lp <= lp_val;
            else if (aeoi_done && rot_aeoi)
                lp <= IR_NUM;
            if (rot_wr)
                rot_aeoi <= rot_val;
        end
    end

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            state      <= ST_IDLE;
            INT        <= 1'b0;
            IR_NUM     <= '0;
            INTA_COUNT <= '0;
            spur_q     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: if (req_above) begin
                    state <= ST_PEND;
                    INT   <= 1'b1;
                end
                ST_PEND: if (INTA_ACK) begin
                    IR_NUM <= req_w.valid ? req_w.idx
                                          : SPURIOUS_IR;
                    spur_q     <= !req_w.valid;
                    INT        <= 1'b0;
                    INTA_COUNT <= 2'd1;
                    state      <= ST_ACK1;
                end
                ST_ACK1: if (INTA_ACK) begin
                    INTA_COUNT <= 2'd2;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pic_interrupt_scheduler.sv
// Self-checking bench: table of single-request vectors plus
// hand-written nesting, rotation, spurious, AEOI and reset cases.
module tb_pic_interrupt_scheduler;

    logic       CLK = 1'b0;
    logic       RST_;
    logic [7:0] IR, MASK, OCW2;
    logic       LEVEL, AEOI, OCW2_WR, INTA_ACK;
    logic       INT;
    logic [2:0] IR_NUM;
    logic [7:0] IRR, ISR;
    logic [1:0] INTA_COUNT;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] num;
        logic [7:0] isr;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [7:0] ir;
        logic [7:0] mask;
        logic [2:0] num;
    } vec_t;
    vec_t vecs[6];

    pic_interrupt_scheduler #(.SYNC_STAGES(2)) dut (
        .CLK(CLK), .RST_(RST_), .IR(IR), .LEVEL(LEVEL),
        .MASK(MASK), .AEOI(AEOI), .OCW2_WR(OCW2_WR),
        .OCW2(OCW2), .INTA_ACK(INTA_ACK), .INT(INT),
        .IR_NUM(IR_NUM), .IRR(IRR), .ISR(ISR),
        .INTA_COUNT(INTA_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic wait_int(input string name);
        int n = 0;
        while (INT !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check({name, "_int"}, 32'(INT), 32'd1);
    endtask

    task automatic ack();
        INTA_ACK = 1'b1;
        tick();
        INTA_ACK = 1'b0;
    endtask

    task automatic wr_ocw2(input logic [7:0] v);
        OCW2    = v;
        OCW2_WR = 1'b1;
        tick();
        OCW2_WR = 1'b0;
    endtask

    task automatic expect_svc(input logic [2:0] num,
                              input logic [7:0] isr);
        exp_t e;
        e.num = num;
        e.isr = isr;
        sb.push_back(e);
    endtask

    // full INTA sequence, compared against the scoreboard head
    task automatic service(input string name);
        exp_t e;
        wait_int(name);
        ack();
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({name, "_num"}, 32'(IR_NUM), 32'(e.num));
            check({name, "_isr"}, 32'(ISR), 32'(e.isr));
        end
        check({name, "_int_low"}, 32'(INT), 32'd0);
        ack();
    endtask

    task automatic do_reset();
        RST_     = 1'b0;
        IR       = '0;
        OCW2_WR  = 1'b0;
        INTA_ACK = 1'b0;
        idle(2);
        RST_ = 1'b1;
        tick();
    endtask

    initial begin
        RST_ = 1'b0; IR = '0; MASK = '0; OCW2 = '0;
        LEVEL = 1'b0; AEOI = 1'b0; OCW2_WR = 1'b0;
        INTA_ACK = 1'b0;

        vecs[0] = '{ir: 8'h01, mask: 8'h00, num: 3'd0};
        vecs[1] = '{ir: 8'h24, mask: 8'h00, num: 3'd2};
        vecs[2] = '{ir: 8'h24, mask: 8'h04, num: 3'd5};
        vecs[3] = '{ir: 8'h80, mask: 8'h00, num: 3'd7};
        vecs[4] = '{ir: 8'hF0, mask: 8'h30, num: 3'd6};
        vecs[5] = '{ir: 8'hFF, mask: 8'hFE, num: 3'd0};

        idle(2);
        check("rst_int", 32'(INT), 32'd0);
        check("rst_num", 32'(IR_NUM), 32'd0);
        check("rst_irr", 32'(IRR), 32'd0);
        check("rst_isr", 32'(ISR), 32'd0);
        check("rst_cnt", 32'(INTA_COUNT), 32'd0);
        RST_ = 1'b1;
        tick();

        // table: one request pattern each, LP=7 fully nested
        for (int i = 0; i < 6; i++) begin
            MASK = vecs[i].mask;
            IR   = vecs[i].ir;
            expect_svc(vecs[i].num, 8'b1 << vecs[i].num);
            service($sformatf("vec%0d", i));
            IR = '0;
            idle(5);
            check($sformatf("vec%0d_irr", i), 32'(IRR), 32'd0);
            wr_ocw2(8'h20);
            idle(4);
            check($sformatf("vec%0d_eoi", i), 32'(ISR), 32'd0);
            check($sformatf("vec%0d_quiet", i), 32'(INT), 32'd0);
        end
        MASK = '0;

        // edge mode IR2+IR5, nested hold-off until EOI
        do_reset();
        IR = 8'h24;
        wait_int("t1");
        ack();
        check("t1_num", 32'(IR_NUM), 32'd2);
        check("t1_isr", 32'(ISR), 32'h04);
        check("t1_irr", 32'(IRR), 32'h20);
        check("t1_cnt1", 32'(INTA_COUNT), 32'd1);
        ack();
        check("t1_cnt2", 32'(INTA_COUNT), 32'd2);
        idle(6);
        check("t1_hold", 32'(INT), 32'd0);
        wr_ocw2(8'h20);
        check("t1_eoi", 32'(ISR), 32'h00);
        expect_svc(3'd5, 8'h20);
        service("t1b");

        // fully nested: IR1 preempts IR4, IR6 does not
        do_reset();
        IR = 8'h10;
        expect_svc(3'd4, 8'h10);
        service("t2a");
        IR = 8'h12;
        expect_svc(3'd1, 8'h12);
        service("t2b");
        IR = 8'h52;
        idle(8);
        check("t2_ir6_blocked", 32'(INT), 32'd0);
        check("t2_ir6_irr", 32'(IRR), 32'h40);

        // rotate on non-specific EOI: LP becomes 3
        do_reset();
        IR = 8'h08;
        expect_svc(3'd3, 8'h08);
        service("t3a");
        IR = '0;
        idle(5);
        wr_ocw2(8'hA0);
        check("t3_isr", 32'(ISR), 32'h00);
        IR = 8'h0C;
        expect_svc(3'd2, 8'h04);
        service("t3b");

        // spurious: level request withdrawn before the ack
        do_reset();
        LEVEL = 1'b1;
        IR = 8'h08;
        wait_int("t4");
        IR = '0;
        idle(6);
        check("t4_irr", 32'(IRR), 32'h00);
        check("t4_int_held", 32'(INT), 32'd1);
        ack();
        check("t4_num", 32'(IR_NUM), 32'd7);
        check("t4_isr", 32'(ISR), 32'h00);
        ack();
        idle(3);
        check("t4_quiet", 32'(INT), 32'd0);
        LEVEL = 1'b0;

        // AEOI with rotation: IR6 clears itself, LP becomes 6
        do_reset();
        AEOI = 1'b1;
        wr_ocw2(8'h80);
        IR = 8'h40;
        expect_svc(3'd6, 8'h40);
        service("t5a");
        check("t5_aeoi_isr", 32'(ISR), 32'h00);
        IR = '0;
        idle(5);
        IR = 8'h81;
        expect_svc(3'd7, 8'h80);
        service("t5b");
        check("t5b_aeoi_isr", 32'(ISR), 32'h00);
        AEOI = 1'b0;
        IR = '0;
        idle(5);

        // reset inside ACK1 with LP moved to 5 beforehand
        wr_ocw2(8'hC5);
        IR = 8'h81;
        wait_int("t6");
        ack();
        check("t6_num_lp5", 32'(IR_NUM), 32'd7);
        check("t6_cnt", 32'(INTA_COUNT), 32'd1);
        RST_ = 1'b0;
        IR = '0;
        #1;
        check("t6_int", 32'(INT), 32'd0);
        check("t6_num", 32'(IR_NUM), 32'd0);
        check("t6_irr", 32'(IRR), 32'd0);
        check("t6_isr", 32'(ISR), 32'd0);
        check("t6_cnt0", 32'(INTA_COUNT), 32'd0);
        tick();
        RST_ = 1'b1;
        idle(2);
        IR = 8'h81;
        expect_svc(3'd0, 8'h01);
        service("t6_lp7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pic_interrupt_scheduler.md
# pic_interrupt_scheduler

Clocked interrupt scheduler for the 8259 PIC: captures the eight IR request lines, arbitrates them under fully-nested or rotating priority against the in-service set, drives INT, runs the two-pulse INTA acknowledge sequence, and applies OCW2 EOI/rotation commands. It sits between the IR pins and the PIC control unit. The control unit supplies mask, trigger mode, AEOI and OCW2 writes. This block returns the winning IR number and the IRR/ISR contents for read-back.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop stages on each IR input; legal values 2..3.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RST_  in  1  reset; one clock, asynchronous assertion, active-low.
- IR  in  8  raw interrupt request pins; asynchronous to CLK.
- LEVEL  in  1  1 = level-triggered, 0 = edge-triggered (ICW1 bit 3).
- MASK  in  8  interrupt mask (OCW1); 1 blocks the IR.
- AEOI  in  1  automatic EOI enable (ICW4 bit 1).
- OCW2_WR  in  1  one-cycle strobe; OCW2 is valid in this cycle.
- OCW2  in  8  command byte: [7]=R, [6]=SL, [5]=EOI, [2:0]=L.
- INTA_ACK  in  1  one-cycle strobe per INTA_ falling edge, already synchronized.
- INT  out  1  interrupt request to the CPU.
- IR_NUM  out  3  IR number for the vector byte.
- IRR  out  8  interrupt request register.
- ISR  out  8  in-service register.
- INTA_COUNT  out  2  0 = idle, 1 = first pulse seen, 2 = second pulse seen.

## Operation
- Request capture:
  - IR passes through SYNC_STAGES flops, giving ir_s.
  - Level mode: IRR = ir_s, registered.
  - Edge mode: an IRR bit sets on a 0→1 transition of ir_s. It clears only when that bit is acknowledged (first INTA), or when ir_s falls before acknowledge.
- Priority uses the lowest-priority register LP (3 bits, reset 7). Priority order runs LP+1 (highest), LP+2, … , LP (lowest), mod 8.
- req_win = highest-priority bit of IRR & ~MASK. isr_top = highest-priority bit of ISR.
- FSM states: IDLE, PEND, ACK1.
  - IDLE → PEND when req_win exists and ranks strictly above isr_top, or ISR = 0. INT goes to 1.
  - PEND, on INTA_ACK:
    - IR_NUM ← req_win, ISR[req_win] ← 1, IRR[req_win] cleared in edge mode, INT ← 0, INTA_COUNT ← 1, go to ACK1.
    - If no req_win exists at this ack (request withdrawn), IR_NUM ← 7 (spurious) and ISR is unchanged.
  - PEND with no INTA_ACK: if req_win vanishes, INT stays 1 until the ack (spurious path).
  - ACK1, on INTA_ACK: INTA_COUNT ← 2, go to IDLE. If AEOI=1, clear ISR[IR_NUM]. If AEOI=1 and rotate_aeoi=1, also set LP ← IR_NUM.
- In IDLE or ACK1, an INTA_ACK that does not match the sequence is ignored; no state change.
- OCW2 commands, decoded from R/SL/EOI:
  - 001: clear isr_top.
  - 011: clear ISR[L].
  - 101: clear isr_top and set LP ← isr_top.
  - 111: clear ISR[L] and set LP ← L.
  - 110: set LP ← L.
  - 100: rotate_aeoi ← 1.
  - 000: rotate_aeoi ← 0.
  - 010: no-op.
  - A non-specific EOI with ISR = 0 has no effect.
- Same-cycle events: ISR_next = (ISR & ~eoi_clr) | ack_set. eoi_clr is computed from the current ISR, so a set wins on the same bit. An LP write from OCW2 takes precedence over an AEOI rotate.
- Mask changes take effect on the next arbitration cycle. They never retract an already-latched IR_NUM.

## Timing
- Reset values: INT=0, IR_NUM=0, IRR=0, ISR=0, INTA_COUNT=0, LP=7, rotate_aeoi=0, state IDLE, sync flops 0.
- RST_ low mid-sequence aborts immediately to these values.
- IR rising at edge n gives IRR set at n+SYNC_STAGES+1 and INT high one cycle later.
- INTA_ACK at edge k updates IR_NUM, ISR and INT at k+1.
- OCW2 effects are visible one cycle after OCW2_WR.
- IR_NUM holds from the first ack until the next first ack.

## Structure
- Shared package pic_pkg holds:
  - FSM state encoding (IDLE/PEND/ACK1).
  - OCW2 command codes (the eight R/SL/EOI values).
  - LP_RESET = 3'd7.
  - SPURIOUS_IR = 3'd7.
- One sub-module, pic_priority_resolver:
  - Combinational rotating find-first over an 8-bit vector, given LP.
  - Returns {valid, index}.
  - Instantiated twice: for IRR & ~MASK and for ISR.

## Test plan
- Edge mode, LP=7, IR=8'h24 → INT rises; two INTA_ACK → IR_NUM=2, ISR=8'h04, IRR=8'h20; INT stays 0 (IR5 below IR2) until EOI 8'h20 → ISR=0, INT re-asserts, next sequence gives IR_NUM=5.
- Fully nested: ISR=8'h10 (IR4) then IR1 requests → INT asserts, IR_NUM=1, ISR=8'h12; IR6 request while ISR=8'h12 → INT stays 0.
- Rotation: OCW2=8'hA0 with ISR=8'h08 → ISR=0, LP=3; then IR=8'h0C → IR_NUM=2 (IR4 highest, IR3 lowest).
- Spurious: level mode, IR3 pulses high, INT rises, IR3 drops before ack → IR_NUM=7, ISR unchanged.
- AEOI=1 with OCW2=8'h80: IR6 acknowledged → ISR=0 after the second ack, LP=6.
- RST_ low in ACK1 → all outputs to reset values on the same edge, LP=7.
